// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between the register-read stage and alu_exec_unit.
// With ALU_EXEC_MULHI_EN defined the bundle also carries the high word of the product.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Busy;
`ifdef ALU_EXEC_MULHI_EN
    logic [WIDTH-1:0] ALUResultHi;
`endif

    modport master (
`ifdef ALU_EXEC_MULHI_EN
        input  ALUResultHi,
`endif
        output InValid,
        output ALUControl,
        output SrcA,
        output SrcB,
        output OutReady,
        input  InReady,
        input  OutValid,
        input  ALUResult,
        input  Zero,
        input  Busy
    );

    modport slave (
`ifdef ALU_EXEC_MULHI_EN
        output ALUResultHi,
`endif
        input  InValid,
        input  ALUControl,
        input  SrcA,
        input  SrcB,
        input  OutReady,
        output InReady,
        output OutValid,
        output ALUResult,
        output Zero,
        output Busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle execution unit: single-cycle add/sub/slt, iterative shift-add multiply.
// Define ALU_EXEC_MULHI_EN to also export the upper word of the signed product.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input logic       CLK,
    input logic       RST,
    alu_exec_if.slave io_bus
);
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    // The upper half of the accumulator only matters when the high word is exported.
`ifdef ALU_EXEC_MULHI_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_sign;
    logic [CNT_W-1:0] r_count;
`ifdef ALU_EXEC_MULHI_EN
    logic [WIDTH-1:0] r_resultHi;
`endif

    logic [WIDTH-1:0] w_aluOut;
    logic [WIDTH-1:0] w_magA;
    logic [WIDTH-1:0] w_magB;
    logic [ACC_W-1:0] w_accNext;
    logic [ACC_W-1:0] w_prod;
    logic             w_accept;

    assign w_accept = io_bus.InValid && (r_state == S_IDLE);

    always_comb begin
        w_aluOut = io_bus.SrcA + io_bus.SrcB;
        case (io_bus.ALUControl)
            OP_SUB:  w_aluOut = io_bus.SrcA - io_bus.SrcB;
            OP_SLT:  w_aluOut = {{(WIDTH-1){1'b0}},
                                 ($signed(io_bus.SrcA) < $signed(io_bus.SrcB))};
            default: w_aluOut = io_bus.SrcA + io_bus.SrcB;
        endcase
    end

    // Multiply on magnitudes, then restore the sign on the final partial sum.
    assign w_magA    = io_bus.SrcA[WIDTH-1] ? -io_bus.SrcA : io_bus.SrcA;
    assign w_magB    = io_bus.SrcB[WIDTH-1] ? -io_bus.SrcB : io_bus.SrcB;
    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod    = r_sign ? -w_accNext : w_accNext;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_sign     <= 1'b0;
            r_count    <= '0;
`ifdef ALU_EXEC_MULHI_EN
            r_resultHi <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (io_bus.ALUControl == OP_MUL) begin
                            r_mcand  <= ACC_W'(w_magA);
                            r_mplier <= w_magB;
                            r_acc    <= '0;
                            r_sign   <= io_bus.SrcA[WIDTH-1] ^ io_bus.SrcB[WIDTH-1];
                            r_count  <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_result   <= w_aluOut;
                            r_zero     <= (w_aluOut == '0);
`ifdef ALU_EXEC_MULHI_EN
                            r_resultHi <= '0;
`endif
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_result   <= w_prod[WIDTH-1:0];
                        r_zero     <= (w_prod[WIDTH-1:0] == '0);
`ifdef ALU_EXEC_MULHI_EN
                        r_resultHi <= w_prod[ACC_W-1:WIDTH];
`endif
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (io_bus.OutReady) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.InReady   = (r_state == S_IDLE);
    assign io_bus.OutValid  = (r_state == S_DONE);
    assign io_bus.Busy      = (r_state != S_IDLE);
    assign io_bus.ALUResult = r_result;
    assign io_bus.Zero      = r_zero;
`ifdef ALU_EXEC_MULHI_EN
    assign io_bus.ALUResultHi = r_resultHi;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: per-cycle compare against a latency/arithmetic model
// plus directed vectors with hand-computed results. Honours ALU_EXEC_MULHI_EN when defined.
module tb_alu_exec_unit;
    localparam int WIDTH       = 32;
    localparam int MUL_LATENCY = WIDTH + 1;

    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    alu_exec_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .io_bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference arithmetic: returns {high word, low word} of the architectural result.
    function automatic logic [63:0] modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        case (op)
            3'b100:  return {32'h0, a - b};
            3'b110:  return {32'h0, 31'h0, ($signed(a) < $signed(b))};
            3'b101: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            default: return {32'h0, a + b};
        endcase
    endfunction

    // Compare process: model tracks busy/hold and cycles left until the result appears.
    logic [63:0] mExp;
    logic        mBusy;
    logic        mHold;
    int          mRemain;

    initial begin
        mExp = '0; mBusy = 1'b0; mHold = 1'b0; mRemain = 0;
        forever begin
            @(negedge CLK);
            #2;
            if (!RST) begin
                mBusy = 1'b0; mHold = 1'b0; mRemain = 0;
                continue;
            end
            checkOutput("cmpInReady", bus.InReady, !mBusy);
            checkOutput("cmpBusy", bus.Busy, mBusy);
            checkOutput("cmpOutValid", bus.OutValid, mHold);
            if (mHold) begin
                checkOutput("cmpALUResult", bus.ALUResult, mExp[31:0]);
                checkOutput("cmpZero", bus.Zero, (mExp[31:0] == 32'h0));
`ifdef ALU_EXEC_MULHI_EN
                checkOutput("cmpALUResultHi", bus.ALUResultHi, mExp[63:32]);
`endif
            end
            if (mHold) begin
                if (bus.OutReady) begin
                    mHold = 1'b0;
                    mBusy = 1'b0;
                end
            end else if (mBusy) begin
                mRemain--;
                if (mRemain == 0) mHold = 1'b1;
            end else if (bus.InValid) begin
                mExp  = modelOp(bus.ALUControl, bus.SrcA, bus.SrcB);
                mBusy = 1'b1;
                if (bus.ALUControl == 3'b101) mRemain = MUL_LATENCY - 1;
                else                          mHold   = 1'b1;
            end
        end
    end

    // Presents an op and returns at the falling edge after the accepting rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        @(negedge CLK);
        bus.InValid    = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        #1;
        while (!bus.InReady && guard < 200) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        if (guard >= 200) checkOutput("acceptTimeout", 64'd0, 64'd1);
        @(negedge CLK);
        bus.InValid = 1'b0;
    endtask

    task automatic waitResult(output int lat, output logic [31:0] res, output logic z, output logic [31:0] hi);
        lat = 1;
        while (!bus.OutValid && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        res = bus.ALUResult;
        z   = bus.Zero;
`ifdef ALU_EXEC_MULHI_EN
        hi  = bus.ALUResultHi;
`else
        hi  = 32'h0;
`endif
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expZero, input logic [31:0] expHi, input int expLat);
        int          lat;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        applyStimulus(op, a, b);
        waitResult(lat, res, z, hi);
        checkOutput({name, "_latency"}, lat, expLat);
        checkOutput({name, "_result"}, res, expRes);
        checkOutput({name, "_zero"}, z, expZero);
`ifdef ALU_EXEC_MULHI_EN
        checkOutput({name, "_hi"}, hi, expHi);
`else
        checkOutput({name, "_hiUnused"}, 32'h0, expHi & 32'h0);
`endif
    endtask

    int          lat;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        sawValid;

    initial begin
        bus.InValid    = 1'b0;
        bus.ALUControl = 3'b010;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        bus.OutReady   = 1'b1;
        RST = 1'b1;
        #1 RST = 1'b0;
        #1;
        checkOutput("rstOutValid", bus.OutValid, 1'b0);
        checkOutput("rstALUResult", bus.ALUResult, 32'h0);
        checkOutput("rstZero", bus.Zero, 1'b0);
        checkOutput("rstBusy", bus.Busy, 1'b0);
        checkOutput("rstInReady", bus.InReady, 1'b1);

        checkOutput("pinMul", modelOp(3'b101, 32'd7, 32'hFFFFFFFD), 64'hFFFFFFFF_FFFFFFEB);
        checkOutput("pinSlt", modelOp(3'b110, 32'hFFFFFFFE, 32'd1), 64'd1);
        checkOutput("pinSub", modelOp(3'b100, 32'd5, 32'd7), 64'h00000000_FFFFFFFE);

        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        runOp("addWrap", 3'b010, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1, 32'h0, 1);
        @(negedge CLK);
        checkOutput("addInReadyBack", bus.InReady, 1'b1);
        runOp("sub", 3'b100, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 32'h0, 1);
        runOp("sltNegPos", 3'b110, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0, 32'h0, 1);
        runOp("sltPosNeg", 3'b110, 32'd1, 32'hFFFFFFFE, 32'd0, 1'b1, 32'h0, 1);
        runOp("mulNeg", 3'b101, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32'hFFFFFFFF, 33);
        runOp("mulZero", 3'b101, 32'd0, 32'h00012345, 32'h0, 1'b1, 32'h0, 33);
        runOp("mulNegNeg", 3'b101, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30, 1'b0, 32'h0, 33);
        runOp("mulMinMin", 3'b101, 32'h80000000, 32'h80000000, 32'h0, 1'b1, 32'h40000000, 33);
        runOp("mulCarryHi", 3'b101, 32'h00010000, 32'h00010000, 32'h0, 1'b1, 32'h1, 33);
        runOp("unusedCode", 3'b111, 32'd4, 32'd9, 32'd13, 1'b0, 32'h0, 1);

        // Reset in the middle of a multiply must drop the operation entirely.
        applyStimulus(3'b101, 32'd7, 32'hFFFFFFFD);
        repeat (8) @(negedge CLK);
        #3 RST = 1'b0;
        #1;
        checkOutput("midRstOutValid", bus.OutValid, 1'b0);
        checkOutput("midRstALUResult", bus.ALUResult, 32'h0);
        checkOutput("midRstZero", bus.Zero, 1'b0);
        checkOutput("midRstBusy", bus.Busy, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checkOutput("midRstInReady", bus.InReady, 1'b1);
        sawValid = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.OutValid) sawValid = 1'b1;
        end
        checkOutput("midRstNoResult", sawValid, 1'b0);

        // Backpressure: result held while OutReady is low, competing op waits.
        bus.OutReady = 1'b0;
        applyStimulus(3'b010, 32'd2, 32'd3);
        waitResult(lat, res, z, hi);
        checkOutput("bpLatency", lat, 1);
        bus.InValid    = 1'b1;
        bus.ALUControl = 3'b010;
        bus.SrcA       = 32'd10;
        bus.SrcB       = 32'd20;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checkOutput("bpOutValid", bus.OutValid, 1'b1);
            checkOutput("bpResult", bus.ALUResult, 32'd5);
            checkOutput("bpInReady", bus.InReady, 1'b0);
        end
        bus.OutReady = 1'b1;
        @(negedge CLK);
        bus.OutReady = 1'b0;
        checkOutput("bpIdleInReady", bus.InReady, 1'b1);
        checkOutput("bpIdleOutValid", bus.OutValid, 1'b0);
        @(negedge CLK);
        bus.InValid = 1'b0;
        checkOutput("bpNewOutValid", bus.OutValid, 1'b1);
        checkOutput("bpNewResult", bus.ALUResult, 32'd30);
        bus.OutReady = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("bpDrained", bus.InReady, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
